// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its result FIFO.
package wb_pkg;

  localparam int NUM_TRD    = 8;
  localparam int TRD_W      = $clog2(NUM_TRD);
  localparam int RO_REG_MAX = 1;
  // Width of the data field held in a buffered entry; the arbiter's DATA_W
  // must not exceed it.
  localparam int WB_DATA_W  = 32;

  typedef struct packed {
    logic [TRD_W-1:0]     trd;
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] data;
    logic                 live;
  } wb_entry_t;

  // r0 and r1 are read-only, so writes aimed at them are dropped.
  function automatic logic is_ro_reg(input logic [4:0] r);
    return r <= 5'(RO_REG_MAX);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-unit results. Entries carry a live bit that can be
// cleared in place by a (thread, register) match or by a whole-thread kill;
// dead entries keep their slot until popped. Optional macro WB_STATS_EN adds a
// per-cycle count of entries killed.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [TRD_W-1:0] kill_trd,
  input  logic [4:0]       kill_rd,
  input  logic             kill_thr_en,
  input  logic [TRD_W-1:0] kill_thr,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] cnt
`ifdef WB_STATS_EN
  ,
  output logic [CNT_W-1:0] kill_num
`endif
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [DEPTH-1:0] kill_hit;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != CNT_W'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  assign head    = mem[rd_ptr];

  // Live entries hit by either kill source; free slots are never live.
  always_comb begin
    kill_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit[i] = mem[i].live &&
                    ((kill_en && mem[i].trd == kill_trd && mem[i].rd == kill_rd) ||
                     (kill_thr_en && mem[i].trd == kill_thr));
    end
  end

`ifdef WB_STATS_EN
  // Number of entries killed this cycle.
  always_comb begin
    kill_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_num = kill_num + CNT_W'(kill_hit[i]);
    end
  end
`endif

  // Storage, pointers and occupancy; popped slots drop their live bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].live <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_hit[i]) mem[i].live <= 1'b0;
      end
      if (do_pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU pipe (always priority) and
// buffered long-unit results into the register file write port, keeping
// write-after-write order and discarding writes for threads being
// re-initialised. Optional macro WB_STATS_EN adds stall_cnt and kill_cnt.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter int  DATA_W     = 32,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [2:0]        alu_trd,
  input  logic [4:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [2:0]        lu_trd,
  input  logic [4:0]        lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              init,
  input  logic [2:0]        new_trd,
  output logic              wr_en,
  output logic [2:0]        wr_trd,
  output logic [4:0]        reg_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  fifo_cnt
`ifdef WB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       kill_cnt
`endif
);

  logic      alu_win;
  logic      fifo_empty;
  logic      push;
  logic      push_dead;
  logic      pop;
  logic      head_emit;
  wb_entry_t push_entry;
  wb_entry_t head;

  // An ALU write for a thread under init never wins, so the slot can drain
  // the FIFO instead.
  assign alu_win    = alu_valid && !is_ro_reg(alu_reg) &&
                      !(init && alu_trd == new_trd);
  assign fifo_empty = (fifo_cnt == '0);
  // No full-bypass: a pop in the same cycle does not reopen the FIFO.
  assign lu_ready   = (fifo_cnt < CNT_W'(FIFO_DEPTH));
  // Read-only targets complete the handshake but are never enqueued.
  assign push       = lu_valid && lu_ready && !is_ro_reg(lu_reg);
  // A result superseded by the same-cycle ALU write or by init enters dead.
  assign push_dead  = (alu_win && alu_trd == lu_trd && alu_reg == lu_reg) ||
                      (init && lu_trd == new_trd);
  assign push_entry = '{trd: lu_trd, rd: lu_reg, data: WB_DATA_W'(lu_data),
                        live: !push_dead};
  assign pop        = !alu_win && !fifo_empty;
  // The head is also suppressed when init hits its thread in the pop cycle.
  assign head_emit  = pop && head.live && !(init && head.trd == new_trd);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .kill_en     (alu_win),
    .kill_trd    (alu_trd),
    .kill_rd     (alu_reg),
    .kill_thr_en (init),
    .kill_thr    (new_trd),
    .head        (head),
    .cnt         (fifo_cnt)
`ifdef WB_STATS_EN
    ,
    .kill_num    (fifo_kill_num)
`endif
  );

  // Registered write port; payload holds its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_trd  <= '0;
      reg_wr  <= '0;
      wr_data <= '0;
    end else if (alu_win) begin
      wr_en   <= 1'b1;
      wr_trd  <= alu_trd;
      reg_wr  <= alu_reg;
      wr_data <= alu_data;
    end else if (head_emit) begin
      wr_en   <= 1'b1;
      wr_trd  <= head.trd;
      reg_wr  <= head.rd;
      wr_data <= DATA_W'(head.data);
    end else begin
      wr_en   <= 1'b0;
    end
  end

`ifdef WB_STATS_EN
  logic [CNT_W-1:0] fifo_kill_num;
  logic [16:0]      kill_sum;

  assign kill_sum = {1'b0, kill_cnt} + 17'(fifo_kill_num) + 17'(push && push_dead);

  // Saturating counters of ALU-over-FIFO stalls and killed entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (!fifo_empty && alu_win && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write scoreboard.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_trd;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [2:0]  lu_trd;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        init;
  logic [2:0]  new_trd;
  logic        wr_en;
  logic [2:0]  wr_trd;
  logic [4:0]  reg_wr;
  logic [31:0] wr_data;
  logic [2:0]  fifo_cnt;
`ifdef WB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] kill_cnt;
`endif

  typedef struct {
    logic [2:0]  trd;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_trd   (alu_trd),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_trd    (lu_trd),
    .lu_reg    (lu_reg),
    .lu_data   (lu_data),
    .init      (init),
    .new_trd   (new_trd),
    .wr_en     (wr_en),
    .wr_trd    (wr_trd),
    .reg_wr    (reg_wr),
    .wr_data   (wr_data),
    .fifo_cnt  (fifo_cnt)
`ifdef WB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alu_valid = 1'b0; alu_trd = '0; alu_reg = '0; alu_data = '0;
    lu_valid  = 1'b0; lu_trd  = '0; lu_reg  = '0; lu_data  = '0;
    init      = 1'b0; new_trd = '0;
  endtask

  task automatic set_alu(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1'b1; alu_trd = t; alu_reg = r; alu_data = d;
  endtask

  task automatic set_lu(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1; lu_trd = t; lu_reg = r; lu_data = d;
  endtask

  task automatic expect_wr(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.trd = t; e.rd = r; e.data = d;
    sb.push_back(e);
  endtask

  // Wait (bounded) for all expected writes, then allow a quiet tail so any
  // extra write is caught by the monitor.
  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Every emitted write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_wr_en", 64'(wr_en), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_trd", 64'(wr_trd), 64'(e.trd));
        chk("reg_wr", 64'(reg_wr), 64'(e.rd));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_trd", 64'(wr_trd), 64'd0);
    chk("rst_reg_wr", 64'(reg_wr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_lu_ready", 64'(lu_ready), 64'd1);

    // ALU only
    tick();
    set_alu(3'd2, 5'd5, 32'hAAAA0001);
    expect_wr(3'd2, 5'd5, 32'hAAAA0001);
    tick();
    clr();
    @(negedge clk);
    chk("alu_wr_en", 64'(wr_en), 64'd1);
    tick();
    @(negedge clk);
    chk("alu_one_shot", 64'(wr_en), 64'd0);

    // Collision: ALU first, LU next cycle
    tick();
    set_alu(3'd0, 5'd3, 32'h0000C0DE);
    set_lu(3'd3, 5'd7, 32'h55);
    expect_wr(3'd0, 5'd3, 32'h0000C0DE);
    expect_wr(3'd3, 5'd7, 32'h55);
    tick();
    clr();
    @(negedge clk);
    chk("coll_cnt1", 64'(fifo_cnt), 64'd1);
    chk("coll_alu_wr", 64'(wr_en), 64'd1);
    tick();
    @(negedge clk);
    chk("coll_cnt0", 64'(fifo_cnt), 64'd0);
    drain("coll_drain");

    // Backpressure: fill while ALU holds the port
    for (int i = 0; i < 4; i++) begin
      set_alu(3'd1, 5'(2 + i), 32'hA0 + 32'(i));
      set_lu(3'd6, 5'(10 + i), 32'h100 + 32'(i));
      expect_wr(3'd1, 5'(2 + i), 32'hA0 + 32'(i));
      tick();
    end
    set_alu(3'd1, 5'd6, 32'hA4);
    set_lu(3'd6, 5'd14, 32'h104);
    expect_wr(3'd1, 5'd6, 32'hA4);
    @(negedge clk);
    chk("bp_full_ready", 64'(lu_ready), 64'd0);
    chk("bp_full_cnt", 64'(fifo_cnt), 64'd4);
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_wr(3'd6, 5'(10 + i), 32'h100 + 32'(i));
    @(negedge clk);
    chk("bp_no_bypass", 64'(lu_ready), 64'd0);
    chk("bp_still_full", 64'(fifo_cnt), 64'd4);
    tick();
    clr();
    @(negedge clk);
    chk("bp_after_pop", 64'(fifo_cnt), 64'd3);
    drain("bp_drain");

    // WAW: later ALU write kills queued entry
    set_lu(3'd1, 5'd9, 32'h11);
    tick();
    clr();
    set_alu(3'd1, 5'd9, 32'h22);
    expect_wr(3'd1, 5'd9, 32'h22);
    tick();
    clr();
    @(negedge clk);
    chk("waw_slot_held", 64'(fifo_cnt), 64'd1);
    tick();
    @(negedge clk);
    chk("waw_dead_pop", 64'(wr_en), 64'd0);
    chk("waw_cnt0", 64'(fifo_cnt), 64'd0);
    drain("waw_drain");

    // WAW: same-cycle push enters dead
    set_alu(3'd2, 5'd9, 32'h33);
    set_lu(3'd2, 5'd9, 32'h44);
    expect_wr(3'd2, 5'd9, 32'h33);
    tick();
    clr();
    @(negedge clk);
    chk("waw_same_cnt", 64'(fifo_cnt), 64'd1);
    tick();
    @(negedge clk);
    chk("waw_same_dead", 64'(wr_en), 64'd0);
    drain("waw_same_drain");

    // Init kills thread 4 entries only
    set_alu(3'd0, 5'd20, 32'hD0);
    set_lu(3'd4, 5'd8, 32'h40);
    expect_wr(3'd0, 5'd20, 32'hD0);
    tick();
    set_alu(3'd0, 5'd21, 32'hD1);
    set_lu(3'd5, 5'd8, 32'h50);
    expect_wr(3'd0, 5'd21, 32'hD1);
    tick();
    clr();
    set_alu(3'd0, 5'd22, 32'hD2);
    init = 1'b1;
    new_trd = 3'd4;
    expect_wr(3'd0, 5'd22, 32'hD2);
    tick();
    clr();
    expect_wr(3'd5, 5'd8, 32'h50);
    @(negedge clk);
    chk("init_cnt", 64'(fifo_cnt), 64'd2);
    tick();
    @(negedge clk);
    chk("init_killed", 64'(wr_en), 64'd0);
    drain("init_drain");

    // Init suppresses a same-thread ALU write
    set_alu(3'd3, 5'd6, 32'h77);
    init = 1'b1;
    new_trd = 3'd3;
    tick();
    clr();
    @(negedge clk);
    chk("init_alu_drop", 64'(wr_en), 64'd0);

    // Read-only filtering
    tick();
    set_alu(3'd2, 5'd1, 32'hBAD);
    tick();
    clr();
    @(negedge clk);
    chk("filter_alu_r1", 64'(wr_en), 64'd0);
    tick();
    set_alu(3'd2, 5'd0, 32'hBAD0);
    set_lu(3'd2, 5'd1, 32'hBAD1);
    @(negedge clk);
    chk("filter_lu_ready", 64'(lu_ready), 64'd1);
    tick();
    clr();
    @(negedge clk);
    chk("filter_alu_r0", 64'(wr_en), 64'd0);
    chk("filter_lu_cnt", 64'(fifo_cnt), 64'd0);

    // Reset mid-drain
    tick();
    for (int i = 0; i < 3; i++) begin
      set_alu(3'd0, 5'(2 + i), 32'hE0 + 32'(i));
      set_lu(3'd7, 5'(2 + i), 32'hF0 + 32'(i));
      expect_wr(3'd0, 5'(2 + i), 32'hE0 + 32'(i));
      tick();
    end
    clr();
    expect_wr(3'd7, 5'd2, 32'hF0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_data", 64'(wr_data), 64'd0);
    chk("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("mid_rst_ready", 64'(lu_ready), 64'd1);
    drain("mid_rst_drain");
    chk("mid_rst_quiet_cnt", 64'(fifo_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
